// File: rtl/io_uart_if.sv
// I/O bus between the processor's I/O port and the UART peripheral.
// The master drives strobes, address and write data; the slave returns registered read data.
interface io_uart_if;
  logic        io_write_en;
  logic        io_read_en;
  logic [31:0] io_address;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;

  modport master (output io_write_en, io_read_en, io_address, io_write_data,
                  input  io_read_data);
  modport slave  (input  io_write_en, io_read_en, io_address, io_write_data,
                  output io_read_data);
endinterface

// File: rtl/io_uart.sv
// Memory-mapped UART: 8-entry TX FIFO, one-entry RX holding register, and a status word.
// Define IO_UART_LOOPBACK_EN to feed the RX synchronizer from the internal uart_tx.
//
// state    | meaning
// TX_IDLE  | line high, waiting for a FIFO entry
// TX_START | start bit (0) for one bit time
// TX_DATA  | 8 data bits, LSB first
// TX_STOP  | stop bit (1); chains straight into TX_START if more data is queued
// RX_IDLE  | waiting for a synchronized falling edge
// RX_START | half a bit time, then confirm the start bit is still low
// RX_DATA  | 8 centre samples, one per bit time
// RX_STOP  | centre sample of the stop bit, then deliver the byte
module io_uart #(
  parameter logic [31:0] BASE_ADDRESS = 32'h18,
  parameter int          BAUD_DIVIDE  = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  io_uart_if.slave   bus,
  output logic       uart_tx,
  input  logic       uart_rx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_DIVIDE);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIVIDE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIVIDE / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic sel_stat, sel_txd, sel_rxd;
  assign sel_stat = (bus.io_address == BASE_ADDRESS);
  assign sel_txd  = (bus.io_address == BASE_ADDRESS + 32'd4);
  assign sel_rxd  = (bus.io_address == BASE_ADDRESS + 32'd8);

  logic unused_in;

  // TX FIFO
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic [7:0]  fifo_out;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign push     = bus.io_write_en && sel_txd && (!full || pop);
  assign fifo_out = fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus.io_write_data[7:0];
  end

  // TX shifter
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  assign pop = !empty && ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (pop) begin
            tx_state <= TX_START;
            tx_shift <= fifo_out;
            tx_cnt   <= BIT_LAST;
            uart_tx  <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            tx_state <= TX_DATA;
            tx_cnt   <= BIT_LAST;
            tx_bit   <= '0;
            uart_tx  <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt - CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LAST;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              uart_tx  <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt - CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt == '0) begin
            if (pop) begin
              tx_state <= TX_START;
              tx_shift <= fifo_out;
              tx_cnt   <= BIT_LAST;
              uart_tx  <= 1'b0;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - CW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX synchronizer and edge detect
  logic rx_src, rx_s1, rx_s2, rx_s3;
`ifdef IO_UART_LOOPBACK_EN
  assign rx_src    = uart_tx;
  assign unused_in = uart_rx ^ (^bus.io_write_data[31:8]);
`else
  assign rx_src    = uart_rx;
  assign unused_in = ^bus.io_write_data[31:8];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx_src;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // RX receiver and holding register
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_byte;
  logic          rx_valid, rx_overrun, rx_frame_err, rd_clear;

  assign rd_clear = bus.io_read_en && sel_rxd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rd_clear) begin
        rx_valid     <= 1'b0;
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
            rx_cnt   <= BIT_LAST;
            rx_bit   <= '0;
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= BIT_LAST;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            // Delivery beats a same-cycle read: the new byte stays valid, no overrun.
            rx_state     <= RX_IDLE;
            rx_byte      <= rx_shift;
            rx_valid     <= 1'b1;
            rx_overrun   <= !rd_clear && (rx_overrun || rx_valid);
            rx_frame_err <= (!rd_clear && rx_frame_err) || !rx_s2;
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Registered read port; unmapped reads leave the last value in place
  logic tx_idle;
  assign tx_idle = empty && (tx_state == TX_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.io_read_data <= '0;
    end else if (bus.io_read_en) begin
      if (sel_stat)
        bus.io_read_data <= {27'b0, tx_idle, rx_frame_err, rx_overrun, rx_valid, !full};
      else if (sel_txd)
        bus.io_read_data <= '0;
      else if (sel_rxd)
        bus.io_read_data <= {24'b0, rx_byte};
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// Self-checking bench for io_uart at BAUD_DIVIDE=4: TX bytes and RX bytes are scoreboarded
// through queues; a line monitor decodes uart_tx frames and checks them against the TX queue.
module tb_io_uart;
  localparam logic [31:0] BASE = 32'h18;
  localparam int          B    = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic uart_tx;
  logic uart_rx = 1'b1;
  logic mon_en = 1'b1;

  int total = 0;
  int bad   = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       exp_valid = 1'b0;

  io_uart_if bus();

  io_uart #(.BASE_ADDRESS(BASE), .BAUD_DIVIDE(B), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.io_write_en   = 1'b1;
    bus.io_read_en    = 1'b0;
    bus.io_address    = a;
    bus.io_write_data = d;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    bus.io_write_en = 1'b0;
    bus.io_read_en  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.io_write_en = 1'b0;
    bus.io_read_en  = 1'b1;
    bus.io_address  = a;
    @(negedge clk);
    bus.io_read_en  = 1'b0;
    d = bus.io_read_data;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic tx_push(input logic [7:0] b);
    wr(BASE + 32'd4, {24'b0, b});
    tx_q.push_back(b);
  endtask

  task automatic rx_data_chk(input string tag);
    logic [31:0] d;
    logic [7:0]  e;
    rd(BASE + 32'd8, d);
    if (rx_q.size() == 0) begin
      chk({tag, "_unexpected"}, d, 32'hFFFF_FFFF);
    end else begin
      e = rx_q.pop_front();
      chk(tag, d, {24'b0, e});
    end
    exp_valid = 1'b0;
  endtask

  // Drive one frame on uart_rx and update the holding-register model.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (B) @(negedge clk);
    end
    uart_rx = stop;
    repeat (B) @(negedge clk);
    uart_rx = 1'b1;
    if (exp_valid) void'(rx_q.pop_back());
    rx_q.push_back(b);
    exp_valid = 1'b1;
  endtask

  // Line monitor: decode each frame near bit centres and compare with the TX scoreboard.
  initial begin
    logic [7:0] mb;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      if (mon_en && reset_n && uart_tx === 1'b0) begin
        repeat (B / 2) @(negedge clk);
        chk("tx_start_bit", {31'b0, uart_tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          mb[i] = uart_tx;
        end
        repeat (B) @(negedge clk);
        chk("tx_stop_bit", {31'b0, uart_tx}, 32'd1);
        if (tx_q.size() == 0) begin
          chk("tx_unexpected_frame", {24'b0, mb}, 32'hFFFF_FFFF);
        end else begin
          eb = tx_q.pop_front();
          chk("tx_byte", {24'b0, mb}, {24'b0, eb});
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    bus.io_write_en   = 1'b0;
    bus.io_read_en    = 1'b0;
    bus.io_address    = '0;
    bus.io_write_data = '0;

    repeat (3) @(negedge clk);
    chk("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    chk("rst_read_data", bus.io_read_data, 32'd0);
    reset_n = 1'b1;
    rd_chk("rst_status", BASE, 32'h11);
    rd_chk("txd_read_zero", BASE + 32'd4, 32'h0);
    rd_chk("status_again", BASE, 32'h11);
    rd_chk("unmapped_hold", BASE + 32'hC, 32'h11);

`ifdef IO_UART_LOOPBACK_EN
    tx_push(8'h5A);
    bus_idle();
    rx_q.push_back(8'h5A);
    exp_valid = 1'b1;
    repeat (60) @(negedge clk);
    rd_chk("lb_status", BASE, 32'h13);
    rx_data_chk("lb_rx_data");
    rd_chk("lb_status_clr", BASE, 32'h11);
`else
    // Single TX: line falls two cycles after the write, idle again after one frame.
    tx_push(8'hA5);
    bus_idle();
    chk("tx_still_high", {31'b0, uart_tx}, 32'd1);
    @(negedge clk);
    chk("tx_fall_n2", {31'b0, uart_tx}, 32'd0);
    repeat (20) @(negedge clk);
    rd_chk("tx_busy_status", BASE, 32'h01);
    repeat (20) @(negedge clk);
    rd_chk("tx_idle_status", BASE, 32'h11);

    // FIFO full/drop: 10 back-to-back writes, the last one finds the FIFO full.
    for (int i = 0; i < 9; i++) tx_push(i[7:0]);
    wr(BASE + 32'd4, 32'h9);
    bus_idle();
    rd_chk("fifo_full_status", BASE, 32'h00);
    wr(BASE, 32'hFF);
    wr(BASE + 32'd8, 32'hFF);
    bus_idle();
    repeat (400) @(negedge clk);
    chk("tx_q_drained", tx_q.size(), 32'd0);
    rd_chk("fifo_drained_status", BASE, 32'h11);

    // RX single byte
    send_rx(8'h3C, 1'b1);
    repeat (8) @(negedge clk);
    rd_chk("rx_status", BASE, 32'h13);
    rx_data_chk("rx_data_3c");
    rd_chk("rx_status_clr", BASE, 32'h11);

    // Overrun
    send_rx(8'h01, 1'b1);
    send_rx(8'h02, 1'b1);
    repeat (8) @(negedge clk);
    rd_chk("ovr_status", BASE, 32'h17);
    rx_data_chk("ovr_data");
    rd_chk("ovr_status_clr", BASE, 32'h11);

    // Frame error: byte still delivered
    send_rx(8'hAA, 1'b0);
    repeat (8) @(negedge clk);
    rd_chk("ferr_status", BASE, 32'h1B);
    rx_data_chk("ferr_data");
    rd_chk("ferr_status_clr", BASE, 32'h11);

    // Glitch on the start bit is rejected
    @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (60) @(negedge clk);
    rd_chk("glitch_status", BASE, 32'h11);
    chk("rx_q_empty", rx_q.size(), 32'd0);
`endif

    // Reset mid-frame forces the line high immediately.
    repeat (60) @(negedge clk);
    mon_en = 1'b0;
    wr(BASE + 32'd4, 32'h33);
    bus_idle();
    @(negedge clk);
    chk("abort_tx_low", {31'b0, uart_tx}, 32'd0);
    #2 reset_n = 1'b0;
    #1 chk("abort_tx_high", {31'b0, uart_tx}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd_chk("abort_status", BASE, 32'h11);
    chk("abort_read_data_after", bus.io_read_data, 32'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
